decode_pipe: RTL and testbench

- Parametrised decode stage with a registered output and valid/ready handshakes on both sides.
- Combines the instruction decoder, a multi-write-port register file with same-cycle write bypass, and a per-register scoreboard that stalls on RAW hazards.
- Sits between the fetch and execute stages.
- Adds flush support and NWB writeback ports, which the single-port, purely combinational decode path does not have.

---
 rtl/decode_pipe_pkg.sv | 84 ++++++++
 rtl/decode_pipe_if.sv | 22 ++
 rtl/decode_pipe_regfile_mp.sv | 49 ++++
 rtl/decode_pipe.sv | 112 +++++++++++
 tb/tb_decode_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pipe_pkg.sv
// rtl/decode_pipe_pkg.sv - shared types, widths and the instruction decoder for decode_pipe
package decode_pipe_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int NWB_DEF  = 2;
    localparam int CREG_W   = $clog2(NREG_DEF);

    typedef logic [XLEN_DEF-1:0] word_t;
    typedef logic [CREG_W-1:0]   creg_addr_t;

    localparam creg_addr_t REG0 = '0;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_STORE  = 7'h23;

    typedef enum logic [2:0] {
        OP_ILLEGAL,
        OP_ALU_IMM,
        OP_ALU_REG,
        OP_LUI,
        OP_STORE
    } op_e;

    typedef struct packed {
        op_e  op;
        logic regwrite;
        logic use_a;
        logic use_b;
    } ctl_t;

    typedef struct packed {
        logic [31:0] instr;
    } fetch_data_t;

    typedef struct packed {
        ctl_t        ctl;
        creg_addr_t  dst;
        creg_addr_t  ra1;
        creg_addr_t  ra2;
        word_t       srca;
        word_t       srcb;
        word_t       imm;
        logic [31:0] raw_instr;
    } decode_data_t;

    typedef struct packed {
        logic       wen;
        creg_addr_t wa;
        word_t      wd;
    } wb_port_t;

    // Operand values are left zero here; the pipe fills them from the register file.
    function automatic decode_data_t decode_instr(logic [31:0] instr);
        decode_data_t d;
        d           = '0;
        d.raw_instr = instr;
        d.dst       = instr[11:7];
        d.ra1       = instr[19:15];
        d.ra2       = instr[24:20];
        case (instr[6:0])
            OPC_OP_IMM: begin
                d.ctl = '{op: OP_ALU_IMM, regwrite: 1'b1, use_a: 1'b1, use_b: 1'b0};
                d.imm = {{(XLEN_DEF-12){instr[31]}}, instr[31:20]};
            end
            OPC_OP: begin
                d.ctl = '{op: OP_ALU_REG, regwrite: 1'b1, use_a: 1'b1, use_b: 1'b1};
            end
            OPC_LUI: begin
                d.ctl = '{op: OP_LUI, regwrite: 1'b1, use_a: 1'b0, use_b: 1'b0};
                d.imm = {{(XLEN_DEF-32){instr[31]}}, instr[31:12], 12'b0};
            end
            OPC_STORE: begin
                d.ctl = '{op: OP_STORE, regwrite: 1'b0, use_a: 1'b1, use_b: 1'b1};
                d.imm = {{(XLEN_DEF-12){instr[31]}}, instr[31:25], instr[11:7]};
            end
            default: d.ctl = '{op: OP_ILLEGAL, regwrite: 1'b0, use_a: 1'b0, use_b: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// rtl/decode_pipe_if.sv - fetch-side and execute-side valid/ready handshake bundle
interface decode_pipe_if;
    import decode_pipe_pkg::*;

    logic         in_valid;
    logic         in_ready;
    fetch_data_t  dataF;
    logic         out_valid;
    logic         out_ready;
    decode_data_t dataD;

    modport master (
        output in_valid, dataF, out_ready,
        input  in_ready, out_valid, dataD
    );

    modport slave (
        input  in_valid, dataF, out_ready,
        output in_ready, out_valid, dataD
    );

endinterface

// File: rtl/decode_pipe_regfile_mp.sv
// rtl/decode_pipe_regfile_mp.sv - NWB-write / 2-read register file with same-cycle write bypass
module decode_pipe_regfile_mp
    import decode_pipe_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWB  = NWB_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  wb_port_t [NWB-1:0]   wb_i,
    input  creg_addr_t           ra1_i,
    input  creg_addr_t           ra2_i,
    output word_t                rd1_o,
    output word_t                rd2_o
);

    word_t [NREG-1:0] regs_q;
    word_t [NREG-1:0] regs_d;

    // Ascending port order lets the highest-index writer win a same-address conflict.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NWB; k++) begin
            if (wb_i[k].wen && wb_i[k].wa != REG0) begin
                regs_d[wb_i[k].wa] = wb_i[k].wd;
            end
        end
    end

    always_comb begin
        rd1_o = regs_q[ra1_i];
        rd2_o = regs_q[ra2_i];
        for (int k = 0; k < NWB; k++) begin
            if (wb_i[k].wen && wb_i[k].wa == ra1_i) rd1_o = wb_i[k].wd;
            if (wb_i[k].wen && wb_i[k].wa == ra2_i) rd2_o = wb_i[k].wd;
        end
        if (ra1_i == REG0) rd1_o = '0;
        if (ra2_i == REG0) rd2_o = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - decode stage: decoder, bypassed register file, RAW scoreboard, output register
module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NWB  = NWB_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    decode_pipe_if.slave             pipe,
    input  logic                     flush,
    input  logic [NWB-1:0]           wen,
    input  creg_addr_t [NWB-1:0]     wa,
    input  logic [NWB-1:0][XLEN-1:0] wd,
    input  logic [NREG-1:0]          sb_clr,
    output logic [NREG-1:0]          busy_o
);

    decode_data_t       dec;
    decode_data_t       data_q, data_d;
    logic               out_valid_q, out_valid_d;
    logic [NREG-1:0]    busy_q, busy_d;
    wb_port_t [NWB-1:0] wb;
    word_t              rd_a, rd_b;
    creg_addr_t [1:0]   src;
    logic [1:0]         src_used;
    logic [1:0]         src_written;
    logic               hazard, in_ready, accept, issue;

    always_comb begin
        dec = decode_instr(pipe.dataF.instr);
        wb  = '0;
        for (int k = 0; k < NWB; k++) begin
            wb[k] = '{wen: wen[k], wa: wa[k], wd: wd[k]};
        end
    end

    decode_pipe_regfile_mp #(.NREG(NREG), .NWB(NWB)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .wb_i  (wb),
        .ra1_i (dec.ra1),
        .ra2_i (dec.ra2),
        .rd1_o (rd_a),
        .rd2_o (rd_b)
    );

    // A busy source is released early when this cycle's writeback produces it (bypass covers it).
    always_comb begin
        src         = {dec.ra2, dec.ra1};
        src_used    = {dec.ctl.use_b, dec.ctl.use_a};
        src_written = '0;
        hazard      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NWB; k++) begin
                if (wen[k] && wa[k] == src[i]) src_written[i] = 1'b1;
            end
            if (src_used[i] && src[i] != REG0 &&
                ((busy_q[src[i]] && !src_written[i]) ||
                 (out_valid_q && data_q.ctl.regwrite && data_q.dst == src[i]))) begin
                hazard = 1'b1;
            end
        end
    end

    assign in_ready = !flush && !hazard && (!out_valid_q || pipe.out_ready);
    assign accept   = pipe.in_valid && in_ready;
    assign issue    = out_valid_q && pipe.out_ready && !flush &&
                      data_q.ctl.regwrite && data_q.dst != REG0;

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            data_d      = dec;
            data_d.srca = rd_a;
            data_d.srcb = rd_b;
        end else if (out_valid_q && pipe.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flush) out_valid_d = 1'b0;

        // Retire clears, then squash clears, then the issue-set so it wins a same-register clear.
        busy_d = busy_q;
        for (int k = 0; k < NWB; k++) begin
            if (wen[k]) busy_d[wa[k]] = 1'b0;
        end
        busy_d = busy_d & ~sb_clr;
        if (issue) busy_d[data_q.dst] = 1'b1;
        busy_d[REG0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
        end
    end

    assign pipe.in_ready  = in_ready;
    assign pipe.out_valid = out_valid_q;
    assign pipe.dataD     = data_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - scoreboard bench for decode_pipe with directed and random stimulus
module tb_decode_pipe;
    import decode_pipe_pkg::*;

    localparam int NWB  = NWB_DEF;
    localparam int NREG = NREG_DEF;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic [NWB-1:0]       wen;
    creg_addr_t [NWB-1:0] wa;
    word_t [NWB-1:0]      wd;
    logic [NREG-1:0]      sb_clr;
    logic [NREG-1:0]      busy_o;

    decode_pipe_if pipe();

    decode_pipe #(.XLEN(XLEN_DEF), .NREG(NREG), .NWB(NWB)) dut (
        .clk    (clk),
        .reset  (reset),
        .pipe   (pipe),
        .flush  (flush),
        .wen    (wen),
        .wa     (wa),
        .wd     (wd),
        .sb_clr (sb_clr),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    decode_data_t    exp_q[$];
    word_t           mregs [NREG];
    logic [NREG-1:0] mbusy;
    logic            mheld_v;
    decode_data_t    mheld;

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_i(int rd, int rs1, int imm);
        logic [11:0] i12;
        i12 = 12'(imm);
        return {i12, 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] enc_r(int rd, int rs1, int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        case ($urandom_range(0, 4))
            0:       opc = 7'h13;
            1:       opc = 7'h33;
            2:       opc = 7'h37;
            3:       opc = 7'h23;
            default: opc = 7'h0B;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom), 5'($urandom_range(0, 7)), opc};
    endfunction

    // Reference decode written from the instruction-format rules with signed arithmetic.
    function automatic decode_data_t ref_decode(logic [31:0] ins);
        decode_data_t      r;
        logic signed [11:0] i12;
        r           = '0;
        r.raw_instr = ins;
        r.dst       = ins[11:7];
        r.ra1       = ins[19:15];
        r.ra2       = ins[24:20];
        r.ctl.op    = OP_ILLEGAL;
        case (ins[6:0])
            7'h13: begin
                r.ctl.op = OP_ALU_IMM; r.ctl.regwrite = 1'b1; r.ctl.use_a = 1'b1;
                i12 = ins[31:20];
                r.imm = word_t'(longint'(i12));
            end
            7'h33: begin
                r.ctl.op = OP_ALU_REG; r.ctl.regwrite = 1'b1;
                r.ctl.use_a = 1'b1; r.ctl.use_b = 1'b1;
            end
            7'h37: begin
                r.ctl.op = OP_LUI; r.ctl.regwrite = 1'b1;
                r.imm = word_t'(longint'(int'(ins & 32'hFFFF_F000)));
            end
            7'h23: begin
                r.ctl.op = OP_STORE; r.ctl.use_a = 1'b1; r.ctl.use_b = 1'b1;
                i12 = {ins[31:25], ins[11:7]};
                r.imm = word_t'(longint'(i12));
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic word_t ref_read(creg_addr_t r);
        word_t v;
        if (r == 0) return '0;
        v = mregs[r];
        for (int k = 0; k < NWB; k++) if (wen[k] && wa[k] == r) v = wd[k];
        return v;
    endfunction

    function automatic bit src_blocked(creg_addr_t s);
        bit wr = 1'b0;
        if (s == 0) return 1'b0;
        for (int k = 0; k < NWB; k++) if (wen[k] && wa[k] == s) wr = 1'b1;
        return (mbusy[s] && !wr) || (mheld_v && mheld.ctl.regwrite && mheld.dst == s);
    endfunction

    // Reference model: predicts handshake/scoreboard each cycle and queues expected outputs.
    decode_data_t m_d;
    logic         m_rdy, m_acc, m_issue;
    initial begin : model
        forever begin
            @(negedge clk);
            if (reset) begin
                foreach (mregs[i]) mregs[i] = '0;
                mbusy   = '0;
                mheld_v = 1'b0;
                exp_q.delete();
            end else begin
                m_d   = ref_decode(pipe.dataF.instr);
                m_rdy = !flush && !(m_d.ctl.use_a && src_blocked(m_d.ra1))
                               && !(m_d.ctl.use_b && src_blocked(m_d.ra2))
                               && (!mheld_v || pipe.out_ready);
                check("in_ready", pipe.in_ready, m_rdy);
                check("busy", busy_o, mbusy);
                check("out_valid", pipe.out_valid, mheld_v);
                m_acc = pipe.in_valid && m_rdy;
                if (m_acc) begin
                    m_d.srca = ref_read(m_d.ra1);
                    m_d.srcb = ref_read(m_d.ra2);
                end
                m_issue = mheld_v && pipe.out_ready && !flush &&
                          mheld.ctl.regwrite && mheld.dst != 0;
                for (int k = 0; k < NWB; k++) if (wen[k] && wa[k] != 0) mregs[wa[k]] = wd[k];
                for (int k = 0; k < NWB; k++) if (wen[k]) mbusy[wa[k]] = 1'b0;
                mbusy = mbusy & ~sb_clr;
                if (m_issue) mbusy[mheld.dst] = 1'b1;
                mbusy[0] = 1'b0;
                if (flush) begin
                    if (mheld_v && !pipe.out_ready) void'(exp_q.pop_back());
                    mheld_v = 1'b0;
                end else if (m_acc) begin
                    mheld_v = 1'b1;
                    mheld   = m_d;
                    exp_q.push_back(m_d);
                end else if (mheld_v && pipe.out_ready) begin
                    mheld_v = 1'b0;
                end
            end
        end
    end

    decode_data_t mon_exp;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset && pipe.out_valid === 1'b1 && pipe.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got dataD %0h expected no output", pipe.dataD);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("dataD", pipe.dataD, mon_exp);
                end
            end
        end
    end

    initial begin : stimulus
        reset          = 1'b1;
        flush          = 1'b0;
        wen            = '0;
        wa             = '0;
        wd             = '0;
        sb_clr         = '0;
        pipe.in_valid  = 1'b0;
        pipe.dataF     = '0;
        pipe.out_ready = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        check("rst_out_valid", pipe.out_valid, 1'b0);
        check("rst_dataD", pipe.dataD, 0);
        check("rst_busy", busy_o, 0);

        pipe.out_ready   = 1'b1;
        pipe.in_valid    = 1'b1;
        pipe.dataF.instr = enc_i(1, 0, 5);
        step();
        pipe.in_valid = 1'b0;
        check("t1_out_valid", pipe.out_valid, 1'b1);
        check("t1_imm", pipe.dataD.imm, 5);
        check("t1_dst", pipe.dataD.dst, 1);
        check("t1_srca", pipe.dataD.srca, 0);
        step();
        check("t1_busy1", busy_o[1], 1'b1);

        pipe.in_valid    = 1'b1;
        pipe.dataF.instr = enc_r(2, 1, 1);
        #1 check("t2_stall0", pipe.in_ready, 1'b0);
        step();
        check("t2_stall1", pipe.in_ready, 1'b0);
        wen[0] = 1'b1; wa[0] = 5'd1; wd[0] = 64'd7;
        #1 check("t2_release", pipe.in_ready, 1'b1);
        step();
        wen = '0; pipe.in_valid = 1'b0;
        check("t2_srca", pipe.dataD.srca, 7);
        check("t2_srcb", pipe.dataD.srcb, 7);
        step();

        pipe.out_ready   = 1'b0;
        pipe.in_valid    = 1'b1;
        pipe.dataF.instr = enc_i(6, 0, 9);
        step();
        pipe.dataF.instr = enc_i(7, 0, 3);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", pipe.in_ready, 1'b0);
            check("bp_hold_instr", pipe.dataD.raw_instr, enc_i(6, 0, 9));
            check("bp_hold_imm", pipe.dataD.imm, 9);
            step();
        end
        pipe.out_ready = 1'b1;
        #1 check("bp_release", pipe.in_ready, 1'b1);
        step();
        pipe.in_valid = 1'b0;
        check("bp_next_instr", pipe.dataD.raw_instr, enc_i(7, 0, 3));
        step();

        wen = 2'b11; wa[0] = 5'd5; wa[1] = 5'd5; wd[0] = 64'hAA; wd[1] = 64'hBB;
        pipe.in_valid    = 1'b1;
        pipe.dataF.instr = enc_r(8, 5, 0);
        step();
        wen = '0;
        check("wb_bypass_x5", pipe.dataD.srca, 64'hBB);
        pipe.dataF.instr = enc_r(9, 5, 5);
        step();
        pipe.in_valid = 1'b0;
        check("wb_stored_x5a", pipe.dataD.srca, 64'hBB);
        check("wb_stored_x5b", pipe.dataD.srcb, 64'hBB);
        step();

        pipe.in_valid    = 1'b1;
        pipe.dataF.instr = enc_i(10, 0, 1);
        step();
        flush = 1'b1;
        pipe.dataF.instr = enc_i(11, 0, 2);
        #1 check("fl_in_ready", pipe.in_ready, 1'b0);
        step();
        flush = 1'b0; pipe.in_valid = 1'b0;
        check("fl_out_valid", pipe.out_valid, 1'b0);
        check("fl_busy10", busy_o[10], 1'b0);
        check("fl_busy11", busy_o[11], 1'b0);

        pipe.in_valid    = 1'b1;
        pipe.dataF.instr = enc_i(3, 0, 4);
        step();
        pipe.in_valid = 1'b0;
        step();
        check("clr_busy3_set", busy_o[3], 1'b1);
        sb_clr = NREG'(1) << 3;
        step();
        sb_clr = '0;
        check("clr_busy3", busy_o[3], 1'b0);

        wen[0] = 1'b1; wa[0] = 5'd0; wd[0] = 64'h55;
        pipe.in_valid    = 1'b1;
        pipe.dataF.instr = enc_r(12, 0, 0);
        step();
        wen = '0;
        check("x0_bypass", pipe.dataD.srca, 0);
        pipe.dataF.instr = enc_i(0, 0, 1);
        step();
        pipe.in_valid = 1'b0;
        check("x0_stored", pipe.dataD.srca, 0);
        step();
        check("x0_busy", busy_o[0], 1'b0);

        for (int c = 0; c < 3000; c++) begin
            reset            = (c == 1500);
            pipe.in_valid    = ($urandom_range(0, 9) < 7);
            pipe.dataF.instr = rand_instr();
            pipe.out_ready   = ($urandom_range(0, 3) != 0);
            flush            = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < NWB; k++) begin
                wen[k] = ($urandom_range(0, 9) < 3);
                wa[k]  = 5'($urandom_range(0, 7));
                wd[k]  = {$urandom, $urandom};
            end
            sb_clr = ($urandom_range(0, 19) == 0) ? NREG'($urandom_range(0, 255)) : '0;
            step();
        end

        reset = 1'b0; flush = 1'b0; wen = '0; sb_clr = '0;
        pipe.in_valid = 1'b0; pipe.out_ready = 1'b1;
        repeat (4) step();
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
